q_chan_controller: RTL
======================

Name: q_chan_controller

Overview:
- Q-channel initiator (power controller side). Drives QREQn to one Q-channel device and tracks its QACCEPTn/QDENY/QACTIVE responses.
- Requests quiescence after a programmable idle hysteresis and gates the device clock while STOPPED.
- Exits STOPPED on device activity, software wake, or disable.
- Sits in the always-on domain next to the device it controls.

Parameters:
- IDLE_CYCLES, 16, consecutive idle cycles in RUN before QREQn is asserted (0 = request on first idle cycle); legal range 0..2**CNT_W-1.
- CNT_W, 8, width of the idle counter and of the deny counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- en_i  input  1  synchronous; 1 = automatic low-power entry enabled.
- wake_req_i  input  1  synchronous software wake / entry inhibit.
- qactive_i  input  1  asynchronous device activity indication.
- qacceptn_i  input  1  asynchronous device accept, active-low.
- qdeny_i  input  1  asynchronous device deny, active-high; tie 0 for devices without deny.
- qreqn_o  output  1  quiescence request, active-low, registered.
- clk_en_o  output  1  device clock-gate enable, registered.
- state_o  output  3  current state encoding, from the package enum.
- stopped_o  output  1  1 while state is STOPPED.
- deny_cnt_o  output  CNT_W  saturating count of denied requests.
- err_o  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async, any time, including mid-handshake):
  - State = RUN; qreqn_o = 1; clk_en_o = 1; stopped_o = 0; err_o = 0; deny_cnt_o = 0; idle counter = 0.
  - Synchronizer reset values: qacceptn = 1, qactive = 0, qdeny = 0.
- Synchronization:
  - qactive_i, qacceptn_i and qdeny_i each pass through a 2-flop synchronizer (suffix _s below).
  - An input edge is visible to the FSM 2 cycles later.
- Idle counter:
  - In RUN with en_i=1, wake_req_i=0, qactive_s=0: increment, saturating at IDLE_CYCLES.
  - Otherwise cleared to 0.
- FSM (registered state; qreqn_o, clk_en_o and stopped_o are flops loaded from the next-state decode, so they change on the same edge as the state):
  - RUN: qreqn=1, clk_en=1. Go to REQUEST when the idle condition holds and counter == IDLE_CYCLES.
  - REQUEST: qreqn=0, clk_en=1.
    - qacceptn_s==0 -> STOPPED.
    - else qdeny_s==1 -> DENIED, and deny_cnt increments (saturating at all-ones).
    - qactive, wake_req_i and en_i are ignored here; QREQn is never withdrawn before accept or deny.
  - STOPPED: qreqn=0, clk_en=0, stopped=1. Go to EXIT when qactive_s==1, wake_req_i==1 or en_i==0.
  - EXIT: qreqn=1, clk_en=1 (device needs its clock to complete the handshake). Go to RUN when qacceptn_s==1.
  - DENIED: qreqn=1, clk_en=1. Go to RUN when qdeny_s==0.
- Latency:
  - With a device that accepts combinationally, qreqn_o falling to clk_en_o falling is 3 cycles (2 sync + 1 FSM).
  - Wake request to clk_en_o rising is 1 cycle.
- Simultaneous events:
  - qacceptn_s==0 and qdeny_s==1 together in REQUEST: accept wins, state -> STOPPED, err_o set.
  - wake_req_i and qactive_s together in STOPPED: single transition to EXIT.
- err_o is sticky (cleared only by reset). It sets on any of:
  - qacceptn_s==0 while in RUN or DENIED;
  - qdeny_s==1 while in RUN, STOPPED or EXIT;
  - qacceptn_s rising while in STOPPED;
  - the REQUEST simultaneous accept+deny case above.
- Errors do not alter FSM transitions.
- Counter wrap: the idle counter never wraps (saturating); deny_cnt_o holds at 2**CNT_W-1.
- Idle counter restarts from 0 on every re-entry to RUN.

Decomposition:
- Package q_chan_pkg holds:
  - typedef enum logic [2:0] q_ctrl_state_t: Q_RUN=0, Q_REQUEST=1, Q_STOPPED=2, Q_EXIT=3, Q_DENIED=4;
  - sync reset-value constants.
- Sub-module: the existing dff2_sync (RESET_VAL parameter), instantiated 3 times.
- FSM, counters and error logic live in q_chan_controller.

Test Plan:
- IDLE_CYCLES=16, en_i=1, qactive_i=0, device accepting 2 cycles after QREQn: qreqn_o falls on cycle 17 after reset release; clk_en_o=0 and stopped_o=1 about 5 cycles later; state_o=2.
- From STOPPED, pulse qactive_i high: clk_en_o=1 and qreqn_o=1 within 3 cycles; state_o=3. After qacceptn_i rises, state_o=0 within 3 cycles; idle counter restarts and qreqn_o stays high for 16 idle cycles.
- Device denies (qdeny_i=1 while qacceptn_i=1), then drops deny: state REQUEST->DENIED->RUN; deny_cnt_o=1; qreqn_o=1 in DENIED; err_o=0. Repeat 300 times with CNT_W=8: deny_cnt_o saturates at 255.
- qactive_i toggles high every 10 cycles with IDLE_CYCLES=16: qreqn_o never falls. With en_i=0 and 100 idle cycles: qreqn_o stays 1.
- Assert reset while in STOPPED and again mid-REQUEST: all outputs return to reset values asynchronously (qreqn_o=1, clk_en_o=1, deny_cnt_o=0, err_o=0).
- Inject qacceptn_i=0 with qdeny_i=1 in REQUEST: state -> STOPPED, err_o=1 and stays 1 until reset. Inject qacceptn_i=0 in RUN: err_o=1, state stays RUN.

Source files
------------

// File: rtl/q_chan_pkg.sv
// Shared types and constants for the Q-channel initiator slice.
package q_chan_pkg;

  typedef enum logic [2:0] {
    Q_RUN     = 3'd0,
    Q_REQUEST = 3'd1,
    Q_STOPPED = 3'd2,
    Q_EXIT    = 3'd3,
    Q_DENIED  = 3'd4
  } q_ctrl_state_t;

  // Idle levels of the device-side handshake inputs.
  localparam logic SYNC_RST_QACCEPTN = 1'b1;
  localparam logic SYNC_RST_QACTIVE  = 1'b0;
  localparam logic SYNC_RST_QDENY    = 1'b0;

endpackage

// File: rtl/dff2_sync.sv
// Two-flop synchronizer with a configurable reset value.
module dff2_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/q_chan_controller.sv
// Q-channel initiator: idle hysteresis, QREQn handshake, device clock gating
// and sticky protocol-error detection.
module q_chan_controller
  import q_chan_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wake_req_i,
  input  logic             qactive_i,
  input  logic             qacceptn_i,
  input  logic             qdeny_i,
  output logic             qreqn_o,
  output logic             clk_en_o,
  output logic [2:0]       state_o,
  output logic             stopped_o,
  output logic [CNT_W-1:0] deny_cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic qactive_s, qacceptn_s, qdeny_s;

  dff2_sync #(.RESET_VAL(SYNC_RST_QACTIVE)) u_sync_qactive (
    .clk(clk), .reset(reset), .d_i(qactive_i), .q_o(qactive_s)
  );
  dff2_sync #(.RESET_VAL(SYNC_RST_QACCEPTN)) u_sync_qacceptn (
    .clk(clk), .reset(reset), .d_i(qacceptn_i), .q_o(qacceptn_s)
  );
  dff2_sync #(.RESET_VAL(SYNC_RST_QDENY)) u_sync_qdeny (
    .clk(clk), .reset(reset), .d_i(qdeny_i), .q_o(qdeny_s)
  );

  q_ctrl_state_t    state_q, state_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0] deny_cnt_q, deny_cnt_d;
  logic             err_q, err_d;
  logic             qacc_prev_q;
  logic             qreqn_q, clk_en_q, stopped_q;
  logic             idle;

  assign idle = en_i & ~wake_req_i & ~qactive_s;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    deny_cnt_d = deny_cnt_q;
    err_d      = err_q;

    if (state_q == Q_RUN && idle) begin
      idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
    end

    // Error detection sits beside the transitions and never redirects them.
    unique case (state_q)
      Q_RUN: begin
        if (idle && idle_cnt_q == IDLE_MAX) state_d = Q_REQUEST;
        if (!qacceptn_s || qdeny_s) err_d = 1'b1;
      end
      Q_REQUEST: begin
        if (!qacceptn_s) begin
          state_d = Q_STOPPED;
          if (qdeny_s) err_d = 1'b1;
        end else if (qdeny_s) begin
          state_d = Q_DENIED;
          if (deny_cnt_q != CNT_SAT) deny_cnt_d = deny_cnt_q + CNT_W'(1);
        end
      end
      Q_STOPPED: begin
        if (qactive_s || wake_req_i || !en_i) state_d = Q_EXIT;
        if (qdeny_s || (qacceptn_s && !qacc_prev_q)) err_d = 1'b1;
      end
      Q_EXIT: begin
        if (qacceptn_s) state_d = Q_RUN;
        if (qdeny_s) err_d = 1'b1;
      end
      Q_DENIED: begin
        if (!qdeny_s) state_d = Q_RUN;
        if (!qacceptn_s) err_d = 1'b1;
      end
      default: state_d = Q_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= Q_RUN;
      idle_cnt_q  <= '0;
      deny_cnt_q  <= '0;
      err_q       <= 1'b0;
      qacc_prev_q <= SYNC_RST_QACCEPTN;
      qreqn_q     <= 1'b1;
      clk_en_q    <= 1'b1;
      stopped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      deny_cnt_q  <= deny_cnt_d;
      err_q       <= err_d;
      qacc_prev_q <= qacceptn_s;
      qreqn_q     <= !(state_d == Q_REQUEST || state_d == Q_STOPPED);
      clk_en_q    <= (state_d != Q_STOPPED);
      stopped_q   <= (state_d == Q_STOPPED);
    end
  end

  assign qreqn_o    = qreqn_q;
  assign clk_en_o   = clk_en_q;
  assign stopped_o  = stopped_q;
  assign state_o    = state_q;
  assign deny_cnt_o = deny_cnt_q;
  assign err_o      = err_q;

endmodule
